// File: rtl/uart_io_bridge.sv
// uart_io_bridge
//   Board-side peer of the core's byte IO handshake. It receives 8N1 frames
//   from uart_rxd into an RX FIFO that the core drains through io_in_*. It
//   also accepts bytes from the core through io_out_* into a TX FIFO that is
//   serialised onto uart_txd as 8N1 frames.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   uart_rxd / uart_txd        serial line in (async, idle high) / out (idle high)
//   io_in_rdy/vld/data         core pulls one received byte (RX FIFO head)
//   io_out_vld/data/rdy        core pushes one byte to transmit
//   rx_overrun                 sticky: received byte dropped, RX FIFO was full
//   rx_frame_err               sticky: received frame had a low stop bit
//
// RX / TX FSM states
//   state   | meaning
//   S_IDLE  | line idle; RX waits for a low rxs, TX waits for a queued byte
//   S_START | start bit; RX re-checks it at mid-bit, TX drives 0
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit; RX checks it and pushes the byte, TX drives 1

module uart_byte_fifo #(
  parameter int LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2:0] FULL_CNT = DEPTH[LOG2:0];

  logic [7:0]      mem_q [DEPTH];
  logic [LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2:0]   count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  // Full/empty come from the registered count, so a push on a full FIFO is
  // dropped even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module uart_io_bridge #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       io_in_rdy,
  output logic       io_in_vld,
  output logic [7:0] io_in_data,
  input  logic       io_out_vld,
  input  logic [7:0] io_out_data,
  output logic       io_out_rdy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam logic [15:0] BIT_TC  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_TC = 16'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      rx_state_q, tx_state_q;
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic [2:0]  rx_bit_q, tx_bit_q;
  logic [7:0]  rx_shift_q, tx_shift_q;
  logic        rx_meta_q, rxs_q;
  logic        txd_q, overrun_q, frame_err_q;

  logic        rx_tc, tx_tc;
  logic        rx_push, rx_pop, rx_empty, rx_full;
  logic        tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]  tx_head;

  assign rx_tc = (rx_cnt_q == '0);
  assign tx_tc = (tx_cnt_q == '0);

  assign rx_push = (rx_state_q == S_STOP) && rx_tc && rxs_q;
  assign io_in_vld = io_in_rdy && !rx_empty;
  assign rx_pop    = io_in_vld;

  assign io_out_rdy = !tx_full;
  assign tx_push    = io_out_vld && io_out_rdy;
  // The stop bit hands over straight to the next start bit when more bytes
  // are queued, so back-to-back frames carry no extra idle time.
  assign tx_pop = ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_tc)) && !tx_empty;

  assign uart_txd     = txd_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

  uart_byte_fifo #(.LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_shift_q),
    .head_o  (io_in_data),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  uart_byte_fifo #(.LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .data_i  (io_out_data),
    .head_o  (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_push && rx_full) overrun_q <= 1'b1;
      case (rx_state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= HALF_TC;
          end
        end
        S_START: begin
          if (rx_tc) begin
            if (!rxs_q) begin
              rx_state_q <= S_DATA;
              rx_cnt_q   <= BIT_TC;
              rx_bit_q   <= '0;
            end else begin
              rx_state_q <= S_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_tc) begin
            rx_shift_q[rx_bit_q] <= rxs_q;
            rx_cnt_q             <= BIT_TC;
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (rx_tc) begin
            if (!rxs_q) frame_err_q <= 1'b1;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // txd is registered from the current state, so the line lags the FSM by
  // one clock; every bit still lasts exactly CLK_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= tx_shift_q[0];
        default: txd_q <= 1'b1;
      endcase
      case (tx_state_q)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_state_q <= S_START;
            tx_cnt_q   <= BIT_TC;
          end
        end
        S_START: begin
          if (tx_tc) begin
            tx_state_q <= S_DATA;
            tx_cnt_q   <= BIT_TC;
            tx_bit_q   <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (tx_tc) begin
            tx_cnt_q   <= BIT_TC;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_q <= S_STOP;
            else                  tx_bit_q   <= tx_bit_q + 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (tx_tc) begin
            if (tx_pop) begin
              tx_shift_q <= tx_head;
              tx_state_q <= S_START;
              tx_cnt_q   <= BIT_TC;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_io_bridge.sv
// Testbench for uart_io_bridge with CLK_PER_BIT=4, FIFO_LOG2=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_io_bridge;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       io_in_rdy = 1'b0;
  logic       io_out_vld = 1'b0;
  logic [7:0] io_out_data = 8'h00;
  logic       uart_txd, io_in_vld, io_out_rdy, rx_overrun, rx_frame_err;
  logic [7:0] io_in_data;

  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b1;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ovr;
    logic       exp_ferr;
    logic       drain;
  } rxvec_t;
  rxvec_t tbl[7];

  always #5 clk = ~clk;

  uart_io_bridge #(.CLK_PER_BIT(CPB), .FIFO_LOG2(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd),
    .io_in_rdy    (io_in_rdy),
    .io_in_vld    (io_in_vld),
    .io_in_data   (io_in_data),
    .io_out_vld   (io_out_vld),
    .io_out_data  (io_out_data),
    .io_out_rdy   (io_out_rdy),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_byte(input string name);
    logic [7:0] exp;
    int n;
    exp = rxq.pop_front();
    n = 0;
    io_in_rdy = 1'b1;
    #1;
    while (!io_in_vld && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_vld"}, 32'(io_in_vld), 32'd1);
    if (io_in_vld) check({name, "_data"}, 32'(io_in_data), 32'(exp));
    @(negedge clk);
    io_in_rdy = 1'b0;
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    n = 0;
    while (txq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(txq.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  // UART line monitor: decodes each frame and compares it with the queue.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rstn && uart_txd === 1'b0) begin
        @(negedge clk);
        check("tx_mon_start", 32'(uart_txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        check("tx_mon_stop", 32'(uart_txd), 32'd1);
        check("tx_mon_expected", 32'(txq.size() != 0), 32'd1);
        if (txq.size() != 0) check("tx_mon_byte", 32'(b), 32'(txq.pop_front()));
      end
    end
  end

  initial begin : main
    logic [9:0] pat;
    logic [7:0] bytes;
    int sent, guard;
    logic stuck;

    // Reset state
    repeat (3) @(negedge clk);
    io_in_rdy = 1'b1;
    #1;
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_ovr", 32'(rx_overrun), 32'd0);
    check("rst_ferr", 32'(rx_frame_err), 32'd0);
    check("rst_in_data", 32'(io_in_data), 32'd0);
    check("rst_in_vld", 32'(io_in_vld), 32'd0);
    check("rst_out_rdy", 32'(io_out_rdy), 32'd1);
    io_in_rdy = 1'b0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Receive 0xA5 and read it in the same cycle rdy rises
    send_frame(8'hA5, 1'b1);
    io_in_rdy = 1'b1;
    #1;
    check("t1_vld", 32'(io_in_vld), 32'd1);
    check("t1_data", 32'(io_in_data), 32'hA5);
    @(negedge clk);
    #1;
    check("t1_empty", 32'(io_in_vld), 32'd0);
    io_in_rdy = 1'b0;

    // Transmit 0x3C: line goes low two clocks after the transfer
    pat = {1'b1, 8'h3C, 1'b0};
    @(negedge clk);
    io_out_vld = 1'b1;
    io_out_data = 8'h3C;
    #1;
    check("t2_rdy", 32'(io_out_rdy), 32'd1);
    txq.push_back(8'h3C);
    @(negedge clk);
    io_out_vld = 1'b0;
    check("t2_lat0", 32'(uart_txd), 32'd1);
    @(negedge clk);
    check("t2_lat1", 32'(uart_txd), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check($sformatf("t2_bit%0d", k / 4), 32'(uart_txd), 32'(pat[k / 4]));
    end
    repeat (4) begin
      @(negedge clk);
      check("t2_idle", 32'(uart_txd), 32'd1);
    end
    wait_tx_drain("t2_drain");

    // Burst with vld held high; rdy must drop once the FIFO holds 4
    sent = 0;
    guard = 0;
    io_out_vld = 1'b1;
    io_out_data = 8'h10;
    while (sent < 6 && guard < 1000) begin
      #1;
      if (io_out_rdy) begin
        txq.push_back(io_out_data);
        sent++;
      end
      @(negedge clk);
      guard++;
      bytes = 8'(8'h10 + sent);
      io_out_data = bytes;
      if (sent == 5 && guard == 5) begin
        #1;
        check("t3_full_rdy", 32'(io_out_rdy), 32'd0);
      end
    end
    io_out_vld = 1'b0;
    check("t3_sent", 32'(sent), 32'd6);
    wait_tx_drain("t3_drain");

    // RX table: overrun, frame error, recovery
    tbl[0] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h66, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop);
      if (tbl[i].stop && rxq.size() < 4) rxq.push_back(tbl[i].data);
      check($sformatf("rx_ovr_%0d", i), 32'(rx_overrun), 32'(tbl[i].exp_ovr));
      check($sformatf("rx_ferr_%0d", i), 32'(rx_frame_err), 32'(tbl[i].exp_ferr));
      if (tbl[i].drain) begin
        while (rxq.size() > 0) read_byte($sformatf("rx_read_%0d", i));
        io_in_rdy = 1'b1;
        #1;
        check($sformatf("rx_empty_%0d", i), 32'(io_in_vld), 32'd0);
        @(negedge clk);
        io_in_rdy = 1'b0;
      end
    end

    // Reset in the middle of a TX frame and an RX frame
    mon_en = 1'b0;
    io_out_vld = 1'b1;
    io_out_data = 8'h00;
    @(negedge clk);
    io_out_data = 8'h81;
    @(negedge clk);
    io_out_vld = 1'b0;
    uart_rxd = 1'b0;
    repeat (12) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    io_in_rdy = 1'b1;
    #1;
    check("t6_txd", 32'(uart_txd), 32'd1);
    check("t6_ovr", 32'(rx_overrun), 32'd0);
    check("t6_ferr", 32'(rx_frame_err), 32'd0);
    check("t6_rx_empty", 32'(io_in_vld), 32'd0);
    check("t6_out_rdy", 32'(io_out_rdy), 32'd1);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    stuck = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || io_in_vld !== 1'b0) stuck = 1'b1;
    end
    check("t6_quiet_after_rst", 32'(stuck), 32'd0);
    io_in_rdy = 1'b0;
    mon_en = 1'b1;
    send_frame(8'h3E, 1'b1);
    rxq.push_back(8'h3E);
    read_byte("t6_rx");
    check("t6_ferr_after", 32'(rx_frame_err), 32'd0);
    io_out_vld = 1'b1;
    io_out_data = 8'h5A;
    txq.push_back(8'h5A);
    @(negedge clk);
    io_out_vld = 1'b0;
    wait_tx_drain("t6_tx_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
